// File: rtl/lsu_bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl_pkg
//   Shared types and helpers for the load/store unit bus controller.
//   - lsu_op_t    : memory operation issued by decode (loads then stores)
//   - lsu_state_t : bus handshake state of the controller
//   - is_store    : true for SB/SH/SW
//   - is_aligned  : natural-alignment rule on the two lowest address bits
// ---------------------------------------------------------------------------
package lsu_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ         = 2'd1,
    WAIT_RVALID = 2'd2
  } lsu_state_t;

  localparam int CNT_W = 16;

  // Stores are the only operations that drive write enable on the bus.
  function automatic logic is_store(input lsu_op_t op);
    logic store;
    store = 1'b0;
    case (op)
      SB, SH, SW: store = 1'b1;
      default:    store = 1'b0;
    endcase
    return store;
  endfunction

  // Bytes may sit anywhere, halves need an even address, words need a
  // multiple-of-four address. Only the two lowest bits matter for this.
  function automatic logic is_aligned(input lsu_op_t op, input logic [1:0] off);
    logic ok;
    ok = 1'b1;
    case (op)
      LH, LHU, SH: ok = ~off[0];
      LW, SW:      ok = (off == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// ---------------------------------------------------------------------------
// lsu_load_extend
//   Combinational lane select and sign/zero extension for load data.
//   Ports:
//     op     in  lsu_op_t          latched load operation
//     offset in  OFF_W             latched byte offset inside the bus word
//     rdata  in  DATA_WIDTH        raw read data from the bus
//     result out 32                right-justified, extended load value
// ---------------------------------------------------------------------------
module lsu_load_extend
  import lsu_bus_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  lsu_op_t                 op,
  input  logic [OFF_W-1:0]        offset,
  input  logic [DATA_WIDTH-1:0]   rdata,
  output logic [31:0]             result
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend according to the
  // operation. Alignment was already enforced at issue, so the selected
  // byte/half/word never straddles the top of the bus word.
  always_comb begin
    shifted = 32'(rdata >> {offset, 3'b000});
    result  = shifted;
    case (op)
      LB:      result = {{24{shifted[7]}}, shifted[7:0]};
      LH:      result = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     result = {24'd0, shifted[7:0]};
      LHU:     result = {16'd0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl
//   Multi-width load/store unit with a registered req/gnt/rvalid data bus
//   handshake, byte-enable generation, store lane steering, load extension,
//   alignment checking and a bus-stall timeout.
//   Ports:
//     clock, reset          rising-edge clock, asynchronous active-low reset
//     lsu_en_ip             decode marks a memory op
//     lsu_operator_ip       LB/LH/LW/LBU/LHU/SB/SH/SW
//     alu_valid_ip          mem_addr_ip is valid
//     mem_addr_ip           effective address
//     store_data_ip         right-justified store data
//     data_req_op           bus request
//     data_addr_op          lane-aligned bus address
//     data_we_op            1 = store
//     data_be_op            byte enables
//     data_wdata_op         steered store data
//     data_gnt_i            bus accepted the request
//     data_rvalid_i         read data valid
//     data_rdata_i          read data
//     load_mem_data_op      extended load result (held between loads)
//     lsu_valid_op          one-cycle completion pulse
//     lsu_busy_op           high while a bus transaction is in flight
//     misaligned_op         one-cycle pulse alongside lsu_valid_op
//     timeout_op            one-cycle pulse alongside lsu_valid_op
// ---------------------------------------------------------------------------
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int BE_W           = DATA_WIDTH / 8,
  localparam int OFF_W          = $clog2(BE_W)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    lsu_en_ip,
  input  lsu_op_t                 lsu_operator_ip,
  input  logic                    alu_valid_ip,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_ip,
  input  logic [31:0]             store_data_ip,
  output logic                    data_req_op,
  output logic [ADDR_WIDTH-1:0]   data_addr_op,
  output logic                    data_we_op,
  output logic [BE_W-1:0]         data_be_op,
  output logic [DATA_WIDTH-1:0]   data_wdata_op,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  output logic [31:0]             load_mem_data_op,
  output logic                    lsu_valid_op,
  output logic                    lsu_busy_op,
  output logic                    misaligned_op,
  output logic                    timeout_op
);

  // The counter reads k during the k-th cycle (from 0) spent in REQ or
  // WAIT_RVALID, so comparing against TIMEOUT_CYCLES-1 aborts after exactly
  // TIMEOUT_CYCLES cycles of waiting.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t             state;
  logic [CNT_W-1:0]       wait_cnt;
  lsu_op_t                op_q;
  logic [OFF_W-1:0]       off_q;

  logic [OFF_W-1:0]       off;
  logic                   aligned;
  logic [ADDR_WIDTH-1:0]  addr_aligned;
  logic [BE_W-1:0]        be_next;
  logic [DATA_WIDTH-1:0]  wdata_next;
  logic [31:0]            load_ext;

  assign off          = mem_addr_ip[OFF_W-1:0];
  assign aligned      = is_aligned(lsu_operator_ip, mem_addr_ip[1:0]);
  assign addr_aligned = {mem_addr_ip[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  // Byte enables follow the access size shifted to the lane offset. Store
  // data is replicated across every lane so whichever lane the enables pick
  // already holds the right bytes; loads drive zero write data.
  always_comb begin
    be_next    = '0;
    wdata_next = '0;
    case (lsu_operator_ip)
      SB: begin
        be_next    = BE_W'(1) << off;
        wdata_next = {BE_W{store_data_ip[7:0]}};
      end
      SH: begin
        be_next    = BE_W'(2'b11) << off;
        wdata_next = {(BE_W / 2){store_data_ip[15:0]}};
      end
      SW: begin
        be_next    = BE_W'(4'hF) << off;
        wdata_next = {(BE_W / 4){store_data_ip}};
      end
      LB, LBU: be_next = BE_W'(1) << off;
      LH, LHU: be_next = BE_W'(2'b11) << off;
      default: be_next = BE_W'(4'hF) << off;
    endcase
  end

  lsu_load_extend #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extend (
    .op     (op_q),
    .offset (off_q),
    .rdata  (data_rdata_i),
    .result (load_ext)
  );

  // Main handshake FSM with registered outputs. Completion, misalignment
  // and timeout are single-cycle pulses, cleared by default every cycle.
  // A grant or rvalid in the same cycle the counter expires takes priority
  // over the timeout. Reset drops everything, including an in-flight
  // request, without producing a completion pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      op_q             <= LB;
      off_q            <= '0;
      data_req_op      <= 1'b0;
      data_addr_op     <= '0;
      data_we_op       <= 1'b0;
      data_be_op       <= '0;
      data_wdata_op    <= '0;
      load_mem_data_op <= '0;
      lsu_valid_op     <= 1'b0;
      lsu_busy_op      <= 1'b0;
      misaligned_op    <= 1'b0;
      timeout_op       <= 1'b0;
    end else begin
      lsu_valid_op  <= 1'b0;
      misaligned_op <= 1'b0;
      timeout_op    <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_en_ip && alu_valid_ip) begin
            if (!aligned) begin
              misaligned_op <= 1'b1;
              lsu_valid_op  <= 1'b1;
            end else begin
              state         <= REQ;
              wait_cnt      <= '0;
              op_q          <= lsu_operator_ip;
              off_q         <= off;
              data_req_op   <= 1'b1;
              data_addr_op  <= addr_aligned;
              data_we_op    <= is_store(lsu_operator_ip);
              data_be_op    <= be_next;
              data_wdata_op <= wdata_next;
              lsu_busy_op   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            data_req_op <= 1'b0;
            if (is_store(op_q)) begin
              state        <= IDLE;
              lsu_valid_op <= 1'b1;
              lsu_busy_op  <= 1'b0;
            end else begin
              state    <= WAIT_RVALID;
              wait_cnt <= '0;
            end
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state        <= IDLE;
            data_req_op  <= 1'b0;
            timeout_op   <= 1'b1;
            lsu_valid_op <= 1'b1;
            lsu_busy_op  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_RVALID: begin
          if (data_rvalid_i) begin
            state            <= IDLE;
            load_mem_data_op <= load_ext;
            lsu_valid_op     <= 1'b1;
            lsu_busy_op      <= 1'b0;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state        <= IDLE;
            timeout_op   <= 1'b1;
            lsu_valid_op <= 1'b1;
            lsu_busy_op  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          data_req_op <= 1'b0;
          lsu_busy_op <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_ctrl
//   Drives a 32-bit and a 64-bit instance in lockstep from the same stimulus
//   and compares both against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_lsu_bus_ctrl;
  import lsu_bus_ctrl_pkg::*;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        lsu_en;
  lsu_op_t     op;
  logic        alu_valid;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;

  logic        req32, we32, valid32, busy32, mis32, to32;
  logic [31:0] addr32, wdata32, ld32;
  logic [3:0]  be32;
  logic        req64, we64, valid64, busy64, mis64, to64;
  logic [31:0] addr64, ld64;
  logic [63:0] wdata64;
  logic [7:0]  be64;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_ld32 = '0;
  logic [31:0] exp_ld64 = '0;

  always #5 clock = ~clock;

  lsu_bus_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut32 (
    .clock(clock), .reset(reset), .lsu_en_ip(lsu_en), .lsu_operator_ip(op),
    .alu_valid_ip(alu_valid), .mem_addr_ip(addr), .store_data_ip(sdata),
    .data_req_op(req32), .data_addr_op(addr32), .data_we_op(we32),
    .data_be_op(be32), .data_wdata_op(wdata32), .data_gnt_i(gnt),
    .data_rvalid_i(rvalid), .data_rdata_i(rdata[31:0]),
    .load_mem_data_op(ld32), .lsu_valid_op(valid32), .lsu_busy_op(busy32),
    .misaligned_op(mis32), .timeout_op(to32)
  );

  lsu_bus_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut64 (
    .clock(clock), .reset(reset), .lsu_en_ip(lsu_en), .lsu_operator_ip(op),
    .alu_valid_ip(alu_valid), .mem_addr_ip(addr), .store_data_ip(sdata),
    .data_req_op(req64), .data_addr_op(addr64), .data_we_op(we64),
    .data_be_op(be64), .data_wdata_op(wdata64), .data_gnt_i(gnt),
    .data_rvalid_i(rvalid), .data_rdata_i(rdata),
    .load_mem_data_op(ld64), .lsu_valid_op(valid64), .lsu_busy_op(busy64),
    .misaligned_op(mis64), .timeout_op(to64)
  );

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_bytes(input lsu_op_t o);
    if (o == LB || o == LBU || o == SB) return 1;
    if (o == LH || o == LHU || o == SH) return 2;
    return 4;
  endfunction

  function automatic bit op_is_store(input lsu_op_t o);
    return (o == SB || o == SH || o == SW);
  endfunction

  function automatic bit op_misaligned(input lsu_op_t o, input logic [31:0] a);
    return (a % op_bytes(o)) != 0;
  endfunction

  function automatic logic [63:0] model_be(input lsu_op_t o, input logic [31:0] a, input int nb);
    longint be = 0;
    int off = int'(a % nb);
    for (int i = 0; i < op_bytes(o); i++) be += longint'(1) << (off + i);
    return 64'(be);
  endfunction

  function automatic logic [63:0] model_wdata(input lsu_op_t o, input logic [31:0] sd, input int nb);
    logic [63:0] w = '0;
    if (!op_is_store(o)) return w;
    for (int j = 0; j < nb; j++) w[8*j +: 8] = sd[8*(j % op_bytes(o)) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] model_addr(input logic [31:0] a, input int nb);
    return 64'(a - (a % nb));
  endfunction

  function automatic logic [31:0] model_load(input lsu_op_t o, input logic [31:0] a,
                                             input logic [63:0] rd, input int nb);
    int off = int'(a % nb);
    int sz = op_bytes(o);
    longint v = 0;
    for (int i = 0; i < sz; i++) v += longint'(rd[8*(off+i) +: 8]) << (8*i);
    if ((o == LB || o == LH) && v >= (longint'(1) << (8*sz - 1))) v -= longint'(1) << (8*sz);
    return 32'(v);
  endfunction

  // Presents one operation and plays the bus side: grant after gnt_delay
  // REQ cycles and rvalid after rv_delay WAIT cycles (delays >= TMO mean
  // the response never arrives). Returns at the negedge where completion
  // is visible so the next call can issue back-to-back.
  task automatic applyStimulus(input lsu_op_t o, input logic [31:0] a, input logic [31:0] sd,
                               input int gnt_delay, input int rv_delay, input logic [63:0] rd);
    bit granted = 0;
    bit got_rv = 0;
    lsu_en = 1'b1; alu_valid = 1'b1; op = o; addr = a; sdata = sd;
    @(negedge clock);
    lsu_en = 1'b0; alu_valid = 1'b0; addr = $urandom; sdata = $urandom;
    op = lsu_op_t'($urandom_range(0, 7));
    if (op_misaligned(o, a)) begin
      checkOutput("mis32", 64'(mis32), 64'(1));
      checkOutput("valid32_mis", 64'(valid32), 64'(1));
      checkOutput("req32_mis", 64'(req32), 64'(0));
      checkOutput("mis64", 64'(mis64), 64'(1));
      checkOutput("valid64_mis", 64'(valid64), 64'(1));
      checkOutput("busy64_mis", 64'(busy64), 64'(0));
      return;
    end
    for (int c = 0; c < TMO; c++) begin
      checkOutput("req32", 64'(req32), 64'(1));
      checkOutput("busy32", 64'(busy32), 64'(1));
      checkOutput("valid32_req", 64'(valid32), 64'(0));
      checkOutput("we32", 64'(we32), 64'(op_is_store(o)));
      checkOutput("addr32", 64'(addr32), model_addr(a, 4));
      checkOutput("be32", 64'(be32), model_be(o, a, 4));
      checkOutput("wdata32", 64'(wdata32), model_wdata(o, sd, 4));
      checkOutput("req64", 64'(req64), 64'(1));
      checkOutput("addr64", 64'(addr64), model_addr(a, 8));
      checkOutput("be64", 64'(be64), model_be(o, a, 8));
      checkOutput("wdata64", wdata64, model_wdata(o, sd, 8));
      rvalid = 1'($urandom_range(0, 1));
      rdata = {$urandom, $urandom};
      if (c == gnt_delay) gnt = 1'b1;
      @(negedge clock);
      gnt = 1'b0; rvalid = 1'b0;
      if (c == gnt_delay) begin
        granted = 1;
        break;
      end
    end
    if (!granted) begin
      checkOutput("to32_req", 64'(to32), 64'(1));
      checkOutput("valid32_to", 64'(valid32), 64'(1));
      checkOutput("req32_to", 64'(req32), 64'(0));
      checkOutput("busy32_to", 64'(busy32), 64'(0));
      checkOutput("ld32_hold", 64'(ld32), 64'(exp_ld32));
      checkOutput("to64_req", 64'(to64), 64'(1));
      checkOutput("req64_to", 64'(req64), 64'(0));
      return;
    end
    if (op_is_store(o)) begin
      checkOutput("valid32_st", 64'(valid32), 64'(1));
      checkOutput("req32_st", 64'(req32), 64'(0));
      checkOutput("busy32_st", 64'(busy32), 64'(0));
      checkOutput("to32_st", 64'(to32), 64'(0));
      checkOutput("valid64_st", 64'(valid64), 64'(1));
      return;
    end
    for (int c = 0; c < TMO; c++) begin
      checkOutput("req32_wait", 64'(req32), 64'(0));
      checkOutput("busy32_wait", 64'(busy32), 64'(1));
      checkOutput("valid32_wait", 64'(valid32), 64'(0));
      checkOutput("busy64_wait", 64'(busy64), 64'(1));
      if (c == rv_delay) begin
        rvalid = 1'b1;
        rdata = rd;
      end
      @(negedge clock);
      rvalid = 1'b0; rdata = {$urandom, $urandom};
      if (c == rv_delay) begin
        got_rv = 1;
        break;
      end
    end
    if (!got_rv) begin
      checkOutput("to32_wait", 64'(to32), 64'(1));
      checkOutput("valid32_tow", 64'(valid32), 64'(1));
      checkOutput("ld32_hold_w", 64'(ld32), 64'(exp_ld32));
      checkOutput("to64_wait", 64'(to64), 64'(1));
      checkOutput("ld64_hold_w", 64'(ld64), 64'(exp_ld64));
    end else begin
      exp_ld32 = model_load(o, a, {32'd0, rd[31:0]}, 4);
      exp_ld64 = model_load(o, a, rd, 8);
      checkOutput("valid32_ld", 64'(valid32), 64'(1));
      checkOutput("to32_ld", 64'(to32), 64'(0));
      checkOutput("ld32", 64'(ld32), 64'(exp_ld32));
      checkOutput("busy32_ld", 64'(busy32), 64'(0));
      checkOutput("valid64_ld", 64'(valid64), 64'(1));
      checkOutput("ld64", 64'(ld64), 64'(exp_ld64));
    end
  endtask

  // Issues a word load and pulls reset asynchronously while it is still in
  // REQ (in_wait=0) or in WAIT_RVALID (in_wait=1).
  task automatic resetMidTransaction(input bit in_wait);
    lsu_en = 1'b1; alu_valid = 1'b1; op = LW; addr = 32'h300; sdata = '0;
    @(negedge clock);
    lsu_en = 1'b0; alu_valid = 1'b0;
    checkOutput("rst_req_before", 64'(req32), 64'(1));
    if (in_wait) begin
      gnt = 1'b1;
      @(negedge clock);
      gnt = 1'b0;
      @(negedge clock);
      checkOutput("rst_busy_before", 64'(busy32), 64'(1));
    end
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_req32", 64'(req32), 64'(0));
    checkOutput("rst_busy32", 64'(busy32), 64'(0));
    checkOutput("rst_valid32", 64'(valid32), 64'(0));
    checkOutput("rst_ld32", 64'(ld32), 64'(0));
    checkOutput("rst_req64", 64'(req64), 64'(0));
    exp_ld32 = '0;
    exp_ld64 = '0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < TMO + 2; i++) begin
      @(negedge clock);
      checkOutput("post_rst_valid", 64'(valid32 | valid64), 64'(0));
      checkOutput("post_rst_to", 64'(to32 | to64), 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    lsu_op_t o;
    logic [31:0] a;
    reset = 1'b0; lsu_en = 1'b0; alu_valid = 1'b0; op = LB;
    addr = '0; sdata = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    #1;
    checkOutput("reset_req32", 64'(req32), 64'(0));
    checkOutput("reset_valid32", 64'(valid32), 64'(0));
    checkOutput("reset_busy32", 64'(busy32), 64'(0));
    checkOutput("reset_ld32", 64'(ld32), 64'(0));
    checkOutput("reset_be64", 64'(be64), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] directed cases");
    applyStimulus(LB, 32'h103, 32'h0, 0, 1, 64'h0000_0000_80FF_1234);
    checkOutput("lb_const", 64'(ld32), 64'h0000_0000_FFFF_FF80);
    applyStimulus(LHU, 32'h102, 32'h0, 1, 0, 64'h0000_0000_BEEF_0000);
    checkOutput("lhu_const", 64'(ld32), 64'h0000_0000_0000_BEEF);
    applyStimulus(SH, 32'h202, 32'h0000_1234, 0, 0, 64'h0);
    applyStimulus(LW, 32'h101, 32'h0, 0, 0, 64'h0);
    @(negedge clock);
    checkOutput("mis_pulse_end", 64'(mis32 | valid32 | req32), 64'(0));
    applyStimulus(SW, 32'h40C, 32'hCAFE_F00D, 3, 0, 64'h0);
    applyStimulus(LW, 32'h100, 32'h0, 0, 9, 64'h0);
    applyStimulus(LH, 32'h106, 32'h0, 3, 3, 64'h8001_7FFE_1122_3344);
    applyStimulus(SB, 32'h120, 32'h0, 9, 0, 64'h0);
    applyStimulus(LB, 32'h105, 32'h0, 0, 0, 64'h0011_2233_4455_6677);
    checkOutput("lb64_lane5", 64'(ld64), 64'h22);
    applyStimulus(SB, 32'h105, 32'h0000_00A5, 0, 0, 64'h0);
    resetMidTransaction(1'b0);
    resetMidTransaction(1'b1);

    $display("[TB] random cases");
    for (int n = 0; n < 200; n++) begin
      o = lsu_op_t'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(op_bytes(o) - 1);
      applyStimulus(o, a, $urandom, $urandom_range(0, TMO + 1), $urandom_range(0, TMO + 1),
                    {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clock);
        checkOutput("idle_valid", 64'(valid32 | valid64), 64'(0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
